ray_march_stepper: RTL and testbench

Per-ray march controller that sits directly upstream of the SDF evaluator. It accepts one ray (origin, unit direction), issues sample points to the SDF pipeline, and consumes the returned distance. It then advances the ray by that distance until the ray hits a surface, exceeds the far distance, or runs out of steps. It reports hit/miss, distance travelled and final point to the shading stage.

---
 rtl/ray_march_stepper_pkg.sv | 53 +++++
 rtl/ray_march_stepper_point_eval.sv | 16 +
 rtl/ray_march_stepper.sv | 162 ++++++++++++++++
 tb/tb_ray_march_stepper.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ray_march_stepper_pkg.sv
// Shared types, Q16.16 arithmetic helpers, march constants and the FSM state
// encoding for the ray march stepper.
package ray_march_stepper_pkg;

  typedef logic signed [31:0] fp;

  typedef struct packed {
    fp x;
    fp y;
    fp z;
  } vec3;

  localparam fp FP_HIT_EPS  = 32'sh0000_0041;
  localparam fp FP_MAX_DIST = 32'sh0014_0000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_UPDATE = 3'd3,
    ST_DONE   = 3'd4
  } march_state_t;

  function automatic fp fp_add(input fp a, input fp b);
    return a + b;
  endfunction

  // Full 64-bit signed product, keep the middle 32 bits (wraps on overflow).
  function automatic fp fp_mul(input fp a, input fp b);
    logic [63:0] prod;
    prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    return prod[47:16];
  endfunction

  function automatic fp fp_sat_add(input fp a, input fp b);
    logic [32:0] s;
    s = {a[31], a} + {b[31], b};
    if (s[32] != s[31]) begin
      return s[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    end else begin
      return s[31:0];
    end
  endfunction

  function automatic vec3 make_vec3(input fp x, input fp y, input fp z);
    vec3 v;
    v.x = x;
    v.y = y;
    v.z = z;
    return v;
  endfunction

endpackage

// File: rtl/ray_march_stepper_point_eval.sv
// Combinational point along a ray: origin + dir * t, per component, using the
// package wrap-around Q16.16 helpers.
module ray_point_eval
  import ray_march_stepper_pkg::*;
(
  input  vec3 origin_i,
  input  vec3 dir_i,
  input  fp   t_i,
  output vec3 point_o
);

  assign point_o = make_vec3(fp_add(origin_i.x, fp_mul(dir_i.x, t_i)),
                             fp_add(origin_i.y, fp_mul(dir_i.y, t_i)),
                             fp_add(origin_i.z, fp_mul(dir_i.z, t_i)));

endmodule

// File: rtl/ray_march_stepper.sv
// Single-ray sphere-tracing controller between ray source, SDF pipeline and
// shading. Optional res_steps output is enabled with RAY_MARCH_STEPS_EN.
module ray_march_stepper
  import ray_march_stepper_pkg::*;
#(
  parameter int MAX_STEPS = 64,
  parameter fp  HIT_EPS   = FP_HIT_EPS,
  parameter fp  MAX_DIST  = FP_MAX_DIST
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ray_valid,
  output logic       ray_ready,
  input  vec3        ray_origin,
  input  vec3        ray_dir,
  output logic       sdf_valid,
  output vec3        sdf_point,
  input  logic       sdf_dist_valid,
  input  fp          sdf_dist,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       res_hit,
  output fp          res_t,
  output vec3        res_point
`ifdef RAY_MARCH_STEPS_EN
  ,
  output logic [7:0] res_steps
`endif
);

  march_state_t state_q, state_d;
  vec3          origin_q, origin_d;
  vec3          dir_q, dir_d;
  fp            t_q, t_d;
  vec3          p_q, p_d;
  logic [7:0]   steps_q, steps_d;
  logic         hit_q, hit_d;
  logic         ray_ready_q, sdf_valid_q, res_valid_q;
  fp            t_sum_s;
  vec3          p_eval_s;

  ray_point_eval u_point_eval (
    .origin_i (origin_q),
    .dir_i    (dir_q),
    .t_i      (t_q),
    .point_o  (p_eval_s)
  );

  // Next-state and datapath update for the march FSM
  always_comb begin
    state_d  = state_q;
    origin_d = origin_q;
    dir_d    = dir_q;
    t_d      = t_q;
    p_d      = p_q;
    steps_d  = steps_q;
    hit_d    = hit_q;
    t_sum_s  = fp_sat_add(t_q, sdf_dist);
    case (state_q)
      ST_IDLE: begin
        if (ray_valid) begin
          origin_d = ray_origin;
          dir_d    = ray_dir;
          t_d      = 32'sd0;
          p_d      = ray_origin;
          steps_d  = 8'd0;
          state_d  = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        steps_d = steps_q + 8'd1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!sdf_dist_valid) begin
          state_d = ST_WAIT;
        end else if (sdf_dist < HIT_EPS) begin
          hit_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          t_d = t_sum_s;
          // On a miss the point stays at the last sampled position.
          if ((t_sum_s > MAX_DIST) || (steps_q == 8'(MAX_STEPS))) begin
            hit_d   = 1'b0;
            state_d = ST_DONE;
          end else begin
            state_d = ST_UPDATE;
          end
        end
      end
      ST_UPDATE: begin
        p_d     = p_eval_s;
        state_d = ST_ISSUE;
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      origin_q    <= '0;
      dir_q       <= '0;
      t_q         <= 32'sd0;
      p_q         <= '0;
      steps_q     <= 8'd0;
      hit_q       <= 1'b0;
      ray_ready_q <= 1'b0;
      sdf_valid_q <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      origin_q    <= origin_d;
      dir_q       <= dir_d;
      t_q         <= t_d;
      p_q         <= p_d;
      steps_q     <= steps_d;
      hit_q       <= hit_d;
      ray_ready_q <= (state_d == ST_IDLE);
      sdf_valid_q <= (state_d == ST_ISSUE);
      res_valid_q <= (state_d == ST_DONE);
    end
  end

  assign ray_ready = ray_ready_q;
  assign sdf_valid = sdf_valid_q;
  assign sdf_point = p_q;
  assign res_valid = res_valid_q;
  assign res_hit   = hit_q;
  assign res_t     = t_q;
  assign res_point = p_q;

`ifdef RAY_MARCH_STEPS_EN
  logic [7:0] res_steps_q;

  // Capture the query count when the ray terminates
  always_ff @(posedge clk) begin
    if (rst) begin
      res_steps_q <= 8'd0;
    end else if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
      res_steps_q <= steps_d;
    end else begin
      res_steps_q <= res_steps_q;
    end
  end

  assign res_steps = res_steps_q;
`endif

endmodule

// File: tb/tb_ray_march_stepper.sv
// Scoreboard bench: two steppers (default and MAX_STEPS=4) driven by a
// latency-3 mock SDF whose distance function is selected per test.
module tb_ray_march_stepper;
  import ray_march_stepper_pkg::*;

  typedef struct {
    int   dut;
    logic hit;
    fp    t;
    vec3  pt;
    int   steps;
    int   base;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       ray_valid_s [2];
  logic       ray_ready_s [2];
  vec3        ray_origin_s [2];
  vec3        ray_dir_s [2];
  logic       sdf_valid_s [2];
  vec3        sdf_point_s [2];
  logic       sdf_dist_valid_s [2];
  fp          sdf_dist_s [2];
  logic       res_valid_s [2];
  logic       res_ready_s [2];
  logic       res_hit_s [2];
  fp          res_t_s [2];
  vec3        res_point_s [2];
  logic [7:0] res_steps_s [2];

  logic [2:0] pv [2];
  fp          pd [2][3];
  int         issue_cnt [2];
  int         mock_mode;
  int         n_vec;
  int         n_miss;
  int         n_res;
  exp_t       sb[$];
  exp_t       mon_e;

  ray_march_stepper u_dut0 (
    .clk(clk), .rst(rst),
    .ray_valid(ray_valid_s[0]), .ray_ready(ray_ready_s[0]),
    .ray_origin(ray_origin_s[0]), .ray_dir(ray_dir_s[0]),
    .sdf_valid(sdf_valid_s[0]), .sdf_point(sdf_point_s[0]),
    .sdf_dist_valid(sdf_dist_valid_s[0]), .sdf_dist(sdf_dist_s[0]),
    .res_valid(res_valid_s[0]), .res_ready(res_ready_s[0]),
    .res_hit(res_hit_s[0]), .res_t(res_t_s[0]), .res_point(res_point_s[0])
`ifdef RAY_MARCH_STEPS_EN
    , .res_steps(res_steps_s[0])
`endif
  );

  ray_march_stepper #(.MAX_STEPS(4)) u_dut1 (
    .clk(clk), .rst(rst),
    .ray_valid(ray_valid_s[1]), .ray_ready(ray_ready_s[1]),
    .ray_origin(ray_origin_s[1]), .ray_dir(ray_dir_s[1]),
    .sdf_valid(sdf_valid_s[1]), .sdf_point(sdf_point_s[1]),
    .sdf_dist_valid(sdf_dist_valid_s[1]), .sdf_dist(sdf_dist_s[1]),
    .res_valid(res_valid_s[1]), .res_ready(res_ready_s[1]),
    .res_hit(res_hit_s[1]), .res_t(res_t_s[1]), .res_point(res_point_s[1])
`ifdef RAY_MARCH_STEPS_EN
    , .res_steps(res_steps_s[1])
`endif
  );

`ifndef RAY_MARCH_STEPS_EN
  assign res_steps_s[0] = 8'd0;
  assign res_steps_s[1] = 8'd0;
`endif

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic fp mock_dist(input int mode, input vec3 p);
    case (mode)
      0:       return 32'sh0001_0000;
      1:       return 32'sh0003_0000 - p.z;
      2:       return 32'sh0000_0000;
      3:       return 32'sh0000_8000;
      default: return 32'shFFFF_0000;
    endcase
  endfunction

  // Latency-3 mock SDF pipeline plus issue counter
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (sdf_valid_s[k]) issue_cnt[k] <= issue_cnt[k] + 1;
      pv[k]    <= {pv[k][1:0], sdf_valid_s[k]};
      pd[k][0] <= mock_dist(mock_mode, sdf_point_s[k]);
      pd[k][1] <= pd[k][0];
      pd[k][2] <= pd[k][1];
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      sdf_dist_valid_s[k] = pv[k][2];
      sdf_dist_s[k]       = pd[k][2];
    end
  end

  // Result monitor: pops the scoreboard on each result handshake
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst && sdf_valid_s[k]) check_val("one_in_flight", pv[k], 3'd0);
      if (!rst && res_valid_s[k] && res_ready_s[k]) begin
        if (sb.size() == 0) begin
          check_val("unexpected_result", 1'b1, 1'b0);
        end else begin
          mon_e = sb.pop_front();
          check_val("res_dut", k, mon_e.dut);
          check_val("res_hit", res_hit_s[k], mon_e.hit);
          check_val("res_t", res_t_s[k], mon_e.t);
          check_val("res_point", res_point_s[k], mon_e.pt);
          check_val("issues", issue_cnt[k] - mon_e.base, mon_e.steps);
`ifdef RAY_MARCH_STEPS_EN
          check_val("res_steps", res_steps_s[k], mon_e.steps);
`endif
        end
        n_res++;
      end
    end
  end

  task automatic check_reset_outputs(input int k, input logic ready_exp);
    check_val("rst_ray_ready", ray_ready_s[k], ready_exp);
    check_val("rst_sdf_valid", sdf_valid_s[k], 1'b0);
    check_val("rst_sdf_point", sdf_point_s[k], 96'd0);
    check_val("rst_res_valid", res_valid_s[k], 1'b0);
    check_val("rst_res_hit", res_hit_s[k], 1'b0);
    check_val("rst_res_t", res_t_s[k], 32'd0);
    check_val("rst_res_point", res_point_s[k], 96'd0);
`ifdef RAY_MARCH_STEPS_EN
    check_val("rst_res_steps", res_steps_s[k], 8'd0);
`endif
  endtask

  task automatic send_ray(input int k, input vec3 o, input vec3 d, input logic push,
                          input logic hit, input fp t, input vec3 pt, input int steps);
    int n;
    n = 0;
    while (!ray_ready_s[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_val("ray_ready", ray_ready_s[k], 1'b1);
    if (push) sb.push_back('{k, hit, t, pt, steps, issue_cnt[k]});
    ray_origin_s[k] = o;
    ray_dir_s[k]    = d;
    ray_valid_s[k]  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ray_valid_s[k] = 1'b0;
    check_val("first_issue", sdf_valid_s[k], 1'b1);
  endtask

  task automatic wait_result(input int budget);
    int start;
    int n;
    start = n_res;
    n = 0;
    while (n_res == start && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (n_res == start) check_val("result_timeout", 1'b0, 1'b1);
  endtask

  vec3 zero_v, dir_z, org3, dir_diag;
  int  n;

  initial begin
    n_vec = 0;
    n_miss = 0;
    n_res = 0;
    mock_mode = 0;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      ray_valid_s[k]  = 1'b0;
      ray_origin_s[k] = '0;
      ray_dir_s[k]    = '0;
      res_ready_s[k]  = 1'b1;
      issue_cnt[k]    = 0;
      pv[k]           = 3'd0;
    end
    zero_v   = make_vec3(32'sh0, 32'sh0, 32'sh0);
    dir_z    = make_vec3(32'sh0, 32'sh0, 32'sh0001_0000);
    org3     = make_vec3(32'sh0001_8000, 32'shFFFE_0000, 32'sh0000_4000);
    dir_diag = make_vec3(32'sh0000_9999, 32'sh0, 32'sh0000_CCCC);

    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) check_reset_outputs(k, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) check_reset_outputs(k, 1'b1);

    // Constant 1.0: runs past the far plane at step 21
    mock_mode = 0;
    send_ray(0, zero_v, dir_z, 1'b1, 1'b0, 32'sh0015_0000,
             make_vec3(32'sh0, 32'sh0, 32'sh0014_0000), 21);
    wait_result(400);

    // Plane at z=3: hit on the second query
    mock_mode = 1;
    send_ray(0, zero_v, dir_z, 1'b1, 1'b1, 32'sh0003_0000,
             make_vec3(32'sh0, 32'sh0, 32'sh0003_0000), 2);
    wait_result(100);

    // Zero distance on the first query
    mock_mode = 2;
    send_ray(0, org3, dir_z, 1'b1, 1'b1, 32'sh0, org3, 1);
    wait_result(100);

    // Step budget of 4 with 0.5 steps
    mock_mode = 3;
    send_ray(1, zero_v, dir_z, 1'b1, 1'b0, 32'sh0002_0000,
             make_vec3(32'sh0, 32'sh0, 32'sh0001_8000), 4);
    wait_result(100);

    // Negative distance, then back-pressure on the result
    mock_mode = 4;
    res_ready_s[0] = 1'b0;
    send_ray(0, org3, dir_z, 1'b1, 1'b1, 32'sh0, org3, 1);
    n = 0;
    while (!res_valid_s[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("hold_res_valid", res_valid_s[0], 1'b1);
    n = issue_cnt[0];
    repeat (10) begin
      @(negedge clk);
      check_val("hold_valid", res_valid_s[0], 1'b1);
      check_val("hold_hit", res_hit_s[0], 1'b1);
      check_val("hold_t", res_t_s[0], 32'd0);
      check_val("hold_point", res_point_s[0], org3);
      check_val("hold_ray_ready", ray_ready_s[0], 1'b0);
      check_val("hold_sdf_valid", sdf_valid_s[0], 1'b0);
    end
    check_val("hold_no_issue", issue_cnt[0] - n, 0);
    res_ready_s[0] = 1'b1;
    wait_result(20);
    @(negedge clk);
    check_val("ready_after_result", ray_ready_s[0], 1'b1);

    // Reset while the first query is outstanding
    mock_mode = 0;
    send_ray(0, org3, dir_z, 1'b0, 1'b0, 32'sh0, zero_v, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs(0, 1'b0);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check_reset_outputs(0, 1'b1);
    end

    // Fresh ray after the reset, oblique direction
    send_ray(0, zero_v, dir_diag, 1'b1, 1'b0, 32'sh0015_0000,
             make_vec3(32'sd39321 * 32'sd20, 32'sh0, 32'sd52428 * 32'sd20), 21);
    wait_result(400);

    repeat (5) @(negedge clk);
    check_val("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
